window_ctrl: RTL
================

WINDOW_CTRL -- requirements
Module: window_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 8, input frame width in pixels (>= K).
REQ-002 The block SHALL have parameter IMG_H, default 8, input frame height in pixels (>= K).
REQ-003 The block SHALL have parameter K, default 3, square convolution kernel size (>= 1).
REQ-004 The block SHALL have parameter STRIDE, default 1, window step in rows and in columns (>= 1).
REQ-005 The block SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 The block SHALL have port start, input, 1, one-cycle frame start request.
REQ-008 The block SHALL have port in_valid, input, 1, upstream pixel present.
REQ-009 The block SHALL have port in_ready, output, 1, block accepts a pixel this cycle.
REQ-010 The block SHALL have port shift_ce, output, 1, clock enable for every line-buffer/window shift register.
REQ-011 The block SHALL have port win_valid, output, 1, window registers hold a complete KxK window.
REQ-012 The block SHALL have port out_row, output, clog2(IMG_H) bits, top row of the current window.
REQ-013 The block SHALL have port out_col, output, clog2(IMG_W) bits, left column of the current window.
REQ-014 The block SHALL have port busy, output, 1, frame in progress.
REQ-015 The block SHALL have port done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE -> RUN SHALL occur on start=1; start SHALL be ignored in RUN and DONE.
REQ-018 in_ready SHALL be 1 only in RUN; busy SHALL be 1 in RUN and DONE.
REQ-019 Accept event = in_valid & in_ready.
REQ-020 shift_ce SHALL equal the accept event combinationally, same cycle; no shift_ce at any other time.
REQ-021 Column counter col SHALL increment on each accept, wrap from IMG_W-1 to 0, and increment row on wrap.
REQ-022 On accept of pixel (IMG_H-1, IMG_W-1), the FSM SHALL go RUN -> DONE and clear row/col to 0.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-024 Stride phase counters rph/cph SHALL count 0..STRIDE-1; each starts at 0 when row/col reaches K-1, advances on row/col increment, and wraps.
REQ-025 Window event on accept: row>=K-1, col>=K-1, rph==0, cph==0.
REQ-026 win_valid SHALL be registered, asserted for exactly one cycle, in the cycle after the accept that caused the window event, aligning with the shift-register update.
REQ-027 out_row/out_col SHALL be registered with win_valid to (row-(K-1), col-(K-1)) of that accept and held until the next window event.
REQ-028 Cycles with in_valid=0 in RUN SHALL stall all counters, and shift_ce SHALL be 0 in those cycles.
REQ-029 Window events on consecutive accepts SHALL produce back-to-back win_valid pulses.

Reset
REQ-030 On rst=1 at any time, including mid-frame, the block SHALL return to IDLE in the next cycle.
REQ-031 On that reset, row, col, rph, cph, out_row and out_col SHALL be 0.
REQ-032 On that reset, in_ready, shift_ce, win_valid, busy and done SHALL be 0.
REQ-033 rst SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-034 IMG_W=4, IMG_H=4, K=3, STRIDE=1, start, then 16 pixels at in_valid=1 -> shift_ce 16 cycles; win_valid after pixel indices 10,11,14,15 with (out_row,out_col)=(0,0),(0,1),(1,0),(1,1); done one cycle after the last accept.
REQ-035 IMG_W=5, IMG_H=5, K=3, STRIDE=2, 25 pixels -> exactly 4 win_valid pulses with (0,0),(0,2),(2,0),(2,2).
REQ-036 Config of REQ-034 with in_valid toggling 1,0 -> same 4 windows and coordinates; shift_ce=0 in every gap cycle; no counter advance in gaps.
REQ-037 rst asserted after 9 accepts in the REQ-034 config -> next cycle IDLE with all outputs 0; a new start plus 16 pixels reproduces the REQ-034 results exactly.
REQ-038 start pulsed during RUN and during DONE -> no state or counter change; a start in the cycle after DONE begins a new frame.
REQ-039 in_valid=1 in IDLE without start -> in_ready=0 and shift_ce=0; no counter movement.

Source files
------------

// File: rtl/window_ctrl.sv
// Sliding-window controller: counts accepted raster pixels, gates the line-buffer
// shift enable, and flags each stride-aligned KxK window with its top-left coordinate.
module window_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic                                          shift_ce,
    output logic                                          win_valid,
    output logic [((IMG_H > 1) ? $clog2(IMG_H) : 1)-1:0]  out_row,
    output logic [((IMG_W > 1) ? $clog2(IMG_W) : 1)-1:0]  out_col,
    output logic                                          busy,
    output logic                                          done
);

    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [RW-1:0] r_row, w_row_next;
    logic [CW-1:0] r_col, w_col_next;
    logic [PW-1:0] r_rph, w_rph_next;
    logic [PW-1:0] r_cph, w_cph_next;
    logic [RW-1:0] r_out_row;
    logic [CW-1:0] r_out_col;
    logic          r_win_valid;
    logic          w_accept;
    logic          w_last;
    logic          w_win_event;
    logic          w_row_inc;
    logic          w_col_inc;

    assign w_accept    = in_valid & in_ready;
    assign shift_ce    = w_accept;
    assign w_last      = (r_row == ROW_LAST) && (r_col == COL_LAST);
    // Window is judged on the pre-increment position: the pixel being accepted
    // is the bottom-right corner of the window.
    assign w_win_event = w_accept && (r_row >= ROW_K1) && (r_col >= COL_K1)
                         && (r_rph == '0) && (r_cph == '0);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_rph_next   = r_rph;
        w_cph_next   = r_cph;
        w_row_inc    = 1'b0;
        w_col_inc    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (w_last) begin
                        w_state_next = S_DONE;
                        w_row_next   = '0;
                        w_col_next   = '0;
                        w_rph_next   = '0;
                        w_cph_next   = '0;
                    end else begin
                        w_col_inc = 1'b1;
                        if (r_col == COL_LAST) begin
                            w_col_next = '0;
                            w_row_next = r_row + RW'(1);
                            w_row_inc  = 1'b1;
                        end else begin
                            w_col_next = r_col + CW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        // Phases restart when the position first reaches K-1 and only advance beyond it.
        if (w_col_inc) begin
            if (w_col_next == COL_K1)
                w_cph_next = '0;
            else if (w_col_next > COL_K1)
                w_cph_next = (r_cph == PH_LAST) ? '0 : r_cph + PW'(1);
        end
        if (w_row_inc) begin
            if (w_row_next == ROW_K1)
                w_rph_next = '0;
            else if (w_row_next > ROW_K1)
                w_rph_next = (r_rph == PH_LAST) ? '0 : r_rph + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_rph       <= '0;
            r_cph       <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_row       <= w_row_next;
            r_col       <= w_col_next;
            r_rph       <= w_rph_next;
            r_cph       <= w_cph_next;
            r_win_valid <= w_win_event;
            if (w_win_event) begin
                r_out_row <= r_row - ROW_K1;
                r_out_col <= r_col - COL_K1;
            end
        end
    end

    assign win_valid = r_win_valid;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;

endmodule
